// File: rtl/lane_interleave_2to1_pkg.sv
// Shared phy_tx byte-pipeline definitions: idle/comma byte, lane indices and
// a pointer-width helper used by the lane FIFOs.
package lane_interleave_2to1_pkg;

  localparam logic [7:0] PHY_IDLE_BYTE = 8'hBC;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Address width for a FIFO of n entries; a 1-entry FIFO still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_interleave_2to1_byte_fifo.sv
// Per-lane byte FIFO. A push into a full FIFO is accepted only when the same
// edge pops; otherwise the byte is dropped and the sticky overflow flag is set.
module byte_fifo
  import lane_interleave_2to1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       ovf
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign ovf     = ovf_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && !do_push) ovf_d = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count makes stale entries
  // unreachable, and leaving it out keeps the array as plain RAM/flops.
  always_ff @(posedge clk_2f) begin
    if (reset && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lane_interleave_2to1.sv
// Two-lane byte interleaver: per-lane FIFOs, round-robin pop of at most one
// byte per cycle, and a registered output that idles on the comma byte.
module lane_interleave_2to1
  import lane_interleave_2to1_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] IDLE_BYTE = PHY_IDLE_BYTE
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic       valid_in0,
  input  logic [7:0] data_in1,
  input  logic       valid_in1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       lane_out,
  output logic       full0,
  output logic       full1,
  output logic       ovf0,
  output logic       ovf1
);

  logic [7:0] head0, head1;
  logic       empty0, empty1;
  logic       pop0, pop1;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  lane_e      lane_q, lane_d;
  lane_e      last_q, last_d;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .push   (valid_in0),
    .din    (data_in0),
    .pop    (pop0),
    .dout   (head0),
    .empty  (empty0),
    .full   (full0),
    .ovf    (ovf0)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk_2f (clk_2f),
    .reset  (reset),
    .push   (valid_in1),
    .din    (data_in1),
    .pop    (pop1),
    .dout   (head1),
    .empty  (empty1),
    .full   (full1),
    .ovf    (ovf1)
  );

  // Arbitration looks only at pre-edge FIFO state, so a byte pushed this
  // edge cannot reach the output until the next one.
  always_comb begin
    pop0   = 1'b0;
    pop1   = 1'b0;
    data_d = IDLE_BYTE;
    valid_d = 1'b0;
    lane_d = lane_q;
    last_d = last_q;
    if (last_q == LANE1) begin
      if (!empty0)      pop0 = 1'b1;
      else if (!empty1) pop1 = 1'b1;
    end else begin
      if (!empty1)      pop1 = 1'b1;
      else if (!empty0) pop0 = 1'b1;
    end
    if (pop0) begin
      data_d  = head0;
      valid_d = 1'b1;
      lane_d  = LANE0;
      last_d  = LANE0;
    end else if (pop1) begin
      data_d  = head1;
      valid_d = 1'b1;
      lane_d  = LANE1;
      last_d  = LANE1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      data_q  <= IDLE_BYTE;
      valid_q <= 1'b0;
      lane_q  <= LANE0;
      last_q  <= LANE1;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;

endmodule

// File: tb/tb_lane_interleave_2to1.sv
// Bench for lane_interleave_2to1: table-driven vectors for reset, single-lane
// and interleave, then queue-model sequences for overflow, full+pop and reset.
module tb_lane_interleave_2to1;

  localparam int DEPTH = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] data_in0, data_in1;
  logic       valid_in0, valid_in1;
  logic [7:0] data_out;
  logic       valid_out, lane_out, full0, full1, ovf0, ovf1;

  lane_interleave_2to1 #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .full0     (full0),
    .full1     (full1),
    .ovf0      (ovf0),
    .ovf1      (ovf1)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       lane;
    logic       full0, full1, ovf0, ovf1;
  } exp_t;

  typedef struct {
    logic       r;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       ev;
    logic [7:0] ed;
    logic       el;
  } vec_t;

  exp_t       sb[$];
  vec_t       vt[$];
  logic [7:0] q0[$], q1[$];
  logic       m_last, m_lane, m_ovf0, m_ovf1;

  int tests = 0;
  int fails = 0;
  int ee_seen = 0;
  int valid_seen = 0;
  bit chk_order = 1'b0;
  int lane1_prev = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: SV queues for the lanes, advanced once per edge.
  task automatic model_edge(input logic r, input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1);
    exp_t e;
    int   sel;
    if (!r) begin
      q0.delete();
      q1.delete();
      m_last = 1'b1;
      m_lane = 1'b0;
      m_ovf0 = 1'b0;
      m_ovf1 = 1'b0;
      e.valid = 1'b0;
      e.data  = IDLE;
    end else begin
      if (m_last) sel = (q0.size() != 0) ? 0 : ((q1.size() != 0) ? 1 : -1);
      else        sel = (q1.size() != 0) ? 1 : ((q0.size() != 0) ? 0 : -1);
      if (sel == 0) begin
        e.data = q0.pop_front(); e.valid = 1'b1; m_lane = 1'b0; m_last = 1'b0;
      end else if (sel == 1) begin
        e.data = q1.pop_front(); e.valid = 1'b1; m_lane = 1'b1; m_last = 1'b1;
      end else begin
        e.data = IDLE; e.valid = 1'b0;
      end
      if (v0) begin
        if (q0.size() < DEPTH) q0.push_back(d0);
        else m_ovf0 = 1'b1;
      end
      if (v1) begin
        if (q1.size() < DEPTH) q1.push_back(d1);
        else m_ovf1 = 1'b1;
      end
    end
    e.lane  = m_lane;
    e.full0 = (q0.size() == DEPTH);
    e.full1 = (q1.size() == DEPTH);
    e.ovf0  = m_ovf0;
    e.ovf1  = m_ovf1;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
    exp_t e;
    reset = r; valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1;
    model_edge(r, v0, d0, v1, d1);
    @(posedge clk_2f);
    #1;
    e = sb.pop_front();
    check("valid_out", valid_out, e.valid);
    check("data_out", data_out, e.data);
    check("lane_out", lane_out, e.lane);
    check("full0", full0, e.full0);
    check("full1", full1, e.full1);
    check("ovf0", ovf0, e.ovf0);
    check("ovf1", ovf1, e.ovf1);
    if (valid_out === 1'b1) valid_seen++;
    if (valid_out === 1'b1 && lane_out === 1'b0 && data_out === 8'hEE) ee_seen++;
    if (chk_order && valid_out === 1'b1 && lane_out === 1'b1) begin
      check("lane1_ascending", (int'(data_out) > lane1_prev), 1'b1);
      lane1_prev = int'(data_out);
    end
  endtask

  task automatic add(input logic r, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1,
                     input logic ev, input logic [7:0] ed, input logic el);
    vec_t v;
    v.r = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.ev = ev; v.ed = ed; v.el = el;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset held 3 cycles with both lanes pushing
    add(0, 1, 8'hFF, 1, 8'hFF, 0, 8'hBC, 0);
    add(0, 1, 8'hFF, 1, 8'hFF, 0, 8'hBC, 0);
    add(0, 1, 8'hFF, 1, 8'hFF, 0, 8'hBC, 0);
    // single lane 0
    add(1, 1, 8'h11, 0, 8'h00, 0, 8'hBC, 0);
    add(1, 1, 8'h22, 0, 8'h00, 1, 8'h11, 0);
    add(1, 1, 8'h33, 0, 8'h00, 1, 8'h22, 0);
    add(1, 0, 8'h00, 0, 8'h00, 1, 8'h33, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'hBC, 0);
    // reset, then both lanes interleaved
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'hBC, 0);
    add(1, 1, 8'hA0, 1, 8'hB0, 0, 8'hBC, 0);
    add(1, 1, 8'hA1, 1, 8'hB1, 1, 8'hA0, 0);
    add(1, 1, 8'hA2, 1, 8'hB2, 1, 8'hB0, 1);
    add(1, 0, 8'h00, 0, 8'h00, 1, 8'hA1, 0);
    add(1, 0, 8'h00, 0, 8'h00, 1, 8'hB1, 1);
    add(1, 0, 8'h00, 0, 8'h00, 1, 8'hA2, 0);
    add(1, 0, 8'h00, 0, 8'h00, 1, 8'hB2, 1);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'hBC, 1);

    foreach (vt[i]) begin
      cycle(vt[i].r, vt[i].v0, vt[i].d0, vt[i].v1, vt[i].d1);
      check($sformatf("vec%0d_valid", i), valid_out, vt[i].ev);
      check($sformatf("vec%0d_data", i), data_out, vt[i].ed);
      check($sformatf("vec%0d_lane", i), lane_out, vt[i].el);
      if (i < 3) begin
        check($sformatf("vec%0d_ovf0", i), ovf0, 1'b0);
        check($sformatf("vec%0d_ovf1", i), ovf1, 1'b0);
      end
    end

    // overflow: lane 1 bytes 01..0A while lane 0 also pushes every cycle
    cycle(0, 0, 8'h00, 0, 8'h00);
    chk_order  = 1'b1;
    lane1_prev = 0;
    for (int i = 0; i < 10; i++) cycle(1, 1, 8'h40 + 8'(i), 1, 8'h01 + 8'(i));
    check("ovf1_set", ovf1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1, 0, 8'h00, 0, 8'h00);
    check("ovf1_sticky", ovf1, 1'b1);
    check("drained_valid", valid_out, 1'b0);
    chk_order = 1'b0;

    // full lane 0 with simultaneous pop
    cycle(0, 0, 8'h00, 0, 8'h00);
    n = 0;
    while (!(q0.size() == DEPTH && m_last == 1'b1) && n < 20) begin
      cycle(1, 1, 8'hC0 + 8'(n), 1, 8'hD0 + 8'(n));
      n++;
    end
    check("fill_reached_full0", full0, 1'b1);
    ee_seen = 0;
    cycle(1, 1, 8'hEE, 0, 8'h00);
    check("full_pop_full0", full0, 1'b1);
    check("full_pop_ovf0", ovf0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 8'h00, 0, 8'h00);
    check("ee_output_once", 8'(ee_seen), 8'd1);
    check("ee_ovf0_clear", ovf0, 1'b0);

    // reset mid-stream with bytes queued on both lanes
    cycle(0, 0, 8'h00, 0, 8'h00);
    n = 0;
    while (!(q0.size() >= 3 && q1.size() >= 3) && n < 20) begin
      cycle(1, 1, 8'h60 + 8'(n), 1, 8'h70 + 8'(n));
      n++;
    end
    cycle(0, 1, 8'h99, 1, 8'h99);
    check("midreset_valid", valid_out, 1'b0);
    check("midreset_data", data_out, IDLE);
    valid_seen = 0;
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'h00, 0, 8'h00);
    check("midreset_nothing_out", 8'(valid_seen), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lane_interleave_2to1.md
Name: lane_interleave_2to1

Overview:
- Upstream stage of the phy_tx byte pipeline. Merges two independent byte lanes (lane 0, lane 1) into a single byte stream on clk_2f.
- Its output feeds the clk_2f output register stage directly.
- Each lane is buffered in a small synchronous FIFO. A round-robin arbiter pops at most one byte per cycle.
- When no data is queued, the block emits the idle/comma byte with valid deasserted.

Parameters:
- DEPTH, 4, entries per lane FIFO; power of two, ≥2
- IDLE_BYTE, 8'hBC, data_out value when valid_out=0

Ports:
- clk_2f  in  1  pipeline clock, all logic on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clk_2f
- data_in0  in  8  lane 0 byte
- valid_in0  in  1  lane 0 push strobe; one byte per cycle while high
- data_in1  in  8  lane 1 byte
- valid_in1  in  1  lane 1 push strobe
- data_out  out  8  merged byte, registered
- valid_out  out  1  data_out carries a popped byte, registered
- lane_out  out  1  source lane of data_out, registered
- full0  out  1  lane 0 FIFO holds DEPTH entries, combinational from count
- full1  out  1  lane 1 FIFO full
- ovf0  out  1  sticky: a lane 0 push was dropped
- ovf1  out  1  sticky: a lane 1 push was dropped

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clk_2f.
- Reset values (reset=0 at posedge):
  - data_out=IDLE_BYTE; valid_out=0; lane_out=0; ovf0=ovf1=0.
  - Both FIFOs empty; pointers and counts cleared.
  - Arbiter last-served pointer = 1, so lane 0 wins first.
  - Reset mid-stream discards all queued bytes; pushes presented during that cycle are ignored.
- FIFO (per lane):
  - Push when valid_inN=1 and (not full, or a pop from the same lane occurs that cycle). Full with a simultaneous pop accepts the push; count is unchanged.
  - Push when full and no pop: byte dropped, ovfN set; ovfN stays 1 until reset.
  - Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Arbiter (evaluated on FIFO state before this edge's pushes):
  - Preferred lane = !last.
  - If the preferred FIFO is non-empty, pop it. Else if the other FIFO is non-empty, pop the other. Else no pop.
  - On pop: data_out<=head byte; valid_out<=1; lane_out<=lane; last<=lane.
  - On no pop: data_out<=IDLE_BYTE; valid_out<=0. lane_out and last hold.
- Latency: a byte pushed at edge k into an empty FIFO appears on data_out after edge k+1 at earliest. An empty FIFO cannot bypass a push to the output in the same edge.
- Throughput: one byte per cycle total. Both lanes busy strictly alternate 0,1,0,1.
- A pushed byte is never reordered within its lane. Dropped bytes are the only loss.

Decomposition:
- Shared header phy_tx_defs.vh holds:
  - IDLE_BYTE (8'hBC), shared with downstream comma insertion
  - lane index width/constants LANE0=0, LANE1=1
  - clog2 helper macro
- One sub-module: byte_fifo (parameter DEPTH). Ports: clk_2f, reset, push, din[7:0], pop, dout[7:0], empty, full, ovf. Instantiated twice.
- Arbiter and output register stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles while driving valid_in0=valid_in1=1 -> data_out=8'hBC, valid_out=0, lane_out=0, ovf0=ovf1=0; after release both FIFOs are empty.
- Single lane: push 8'h11,8'h22,8'h33 on lane 0 at edges 1-3 -> valid_out=1 after edges 2,3,4 with data 11,22,33 and lane_out=0; then data_out=BC, valid_out=0.
- Interleave: both lanes pushed every cycle (lane0 A0,A1,A2; lane1 B0,B1,B2) -> output sequence A0,B0,A1,B1,A2,B2 with lane_out 0,1,0,1,0,1.
- Overflow: with DEPTH=4, lane 1 pushes 8'h01..8'h0A in 10 consecutive cycles while lane 0 is saturated -> ovf1 goes high on the first dropped push and stays high; the lane 1 bytes that are output appear in ascending order with no duplicates.
- Full with simultaneous pop: fill lane 0 to full, then push 8'hEE in the same cycle lane 0 is popped -> push accepted, ovf0 stays 0, 8'hEE is eventually output.
- Reset mid-stream: reset=0 for one cycle with 3 bytes queued per lane -> next cycle valid_out=0, data_out=BC; no queued byte is ever output.
